// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: default widths, reserved tag and source encoding.
// Purely declarative; no logic lives here.
package cdb_arbiter_pkg;

    localparam int TAG_WIDTH_DEF  = 4;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int FIFO_DEPTH_DEF = 4;

    // Tag 0 means "no dependency" and is never broadcast.
    localparam int TAG_NONE = 0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Purpose: synchronous FIFO with flush, head view, occupancy count and full/empty flags.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: caller must not push when full or pop when empty; flush empties in one cycle.
module cdb_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage needs no reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Purpose: round-robin share of the common data bus between ALU and LSB result producers.
// Latency: 1 cycle from accept to cdb_valid when the producer's FIFO is empty and it wins.
// Backpressure: per-producer ready drops when its FIFO is full; rdy_in=0 freezes everything.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear,
    input  logic                  alu_valid,
    input  logic [TAG_WIDTH-1:0]  alu_tag,
    input  logic [DATA_WIDTH-1:0] alu_value,
    output logic                  alu_ready,
    input  logic                  lsb_valid,
    input  logic [TAG_WIDTH-1:0]  lsb_tag,
    input  logic [DATA_WIDTH-1:0] lsb_value,
    output logic                  lsb_ready,
    output logic                  cdb_valid,
    output logic [TAG_WIDTH-1:0]  cdb_tag,
    output logic [DATA_WIDTH-1:0] cdb_value,
    output logic                  cdb_src
);

    localparam int EW = TAG_WIDTH + DATA_WIDTH;
    localparam int CW = cnt_width(FIFO_DEPTH);

    logic          active;
    logic          alu_real, lsb_real;
    logic          alu_has, lsb_has;
    logic          grant_alu, grant_lsb;
    logic          alu_push, alu_pop, lsb_push, lsb_pop;
    logic [EW-1:0] alu_head, lsb_head;
    logic [EW-1:0] alu_cand, lsb_cand, win_dat;
    logic [CW-1:0] alu_count, lsb_count;
    logic          alu_full, lsb_full, alu_empty, lsb_empty;
    cdb_src_e      rr_ptr;

    assign active    = rdy_in && !clear && !rst_in;
    assign alu_ready = !alu_full;
    assign lsb_ready = !lsb_full;

    // Tag-0 results are consumed from the producer but never become candidates.
    assign alu_real = alu_valid && alu_ready && active && (alu_tag != TAG_WIDTH'(TAG_NONE));
    assign lsb_real = lsb_valid && lsb_ready && active && (lsb_tag != TAG_WIDTH'(TAG_NONE));

    assign alu_has  = active && ((alu_count != '0) || alu_real);
    assign lsb_has  = active && ((lsb_count != '0) || lsb_real);
    assign alu_cand = alu_empty ? {alu_tag, alu_value} : alu_head;
    assign lsb_cand = lsb_empty ? {lsb_tag, lsb_value} : lsb_head;

    // rr_ptr names the side that wins a tie; it flips away from each winner.
    assign grant_lsb = lsb_has && (!alu_has || (rr_ptr == SRC_LSB));
    assign grant_alu = alu_has && !grant_lsb;
    assign win_dat   = grant_lsb ? lsb_cand : alu_cand;

    assign alu_pop  = grant_alu && !alu_empty;
    assign lsb_pop  = grant_lsb && !lsb_empty;
    assign alu_push = alu_real && !(grant_alu && alu_empty);
    assign lsb_push = lsb_real && !(grant_lsb && lsb_empty);

    cdb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .flush    (clear),
        .push     (alu_push),
        .push_dat ({alu_tag, alu_value}),
        .pop      (alu_pop),
        .head_dat (alu_head),
        .count    (alu_count),
        .full     (alu_full),
        .empty    (alu_empty)
    );

    cdb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .flush    (clear),
        .push     (lsb_push),
        .push_dat ({lsb_tag, lsb_value}),
        .pop      (lsb_pop),
        .head_dat (lsb_head),
        .count    (lsb_count),
        .full     (lsb_full),
        .empty    (lsb_empty)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            rr_ptr    <= SRC_ALU;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= SRC_ALU;
        end else if (rdy_in) begin
            if (grant_alu || grant_lsb) begin
                rr_ptr    <= grant_alu ? SRC_LSB : SRC_ALU;
                cdb_valid <= 1'b1;
                cdb_tag   <= win_dat[EW-1:DATA_WIDTH];
                cdb_value <= win_dat[DATA_WIDTH-1:0];
                cdb_src   <= grant_lsb ? SRC_LSB : SRC_ALU;
            end else begin
                cdb_valid <= 1'b0;
                cdb_tag   <= '0;
                cdb_value <= '0;
                cdb_src   <= SRC_ALU;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised and directed stimulus for cdb_arbiter checked against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int TW  = 4;
    localparam int DW  = 32;
    localparam int DEP = 4;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] val;
    } item_t;

    logic          clk_in;
    logic          rst_in, rdy_in, clear;
    logic          alu_valid, lsb_valid;
    logic [TW-1:0] alu_tag, lsb_tag;
    logic [DW-1:0] alu_value, lsb_value;
    logic          alu_ready, lsb_ready;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_value;
    logic          cdb_src;

    cdb_arbiter #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEP)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .clear     (clear),
        .alu_valid (alu_valid),
        .alu_tag   (alu_tag),
        .alu_value (alu_value),
        .alu_ready (alu_ready),
        .lsb_valid (lsb_valid),
        .lsb_tag   (lsb_tag),
        .lsb_value (lsb_value),
        .lsb_ready (lsb_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            assert (dut.u_alu_fifo.count <= DEP) else $error("alu fifo count out of range");
            assert (dut.u_lsb_fifo.count <= DEP) else $error("lsb fifo count out of range");
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state: per-producer queues plus the last granted side.
    item_t qa[$], qb[$];
    item_t sa[$], sb[$];
    bit    last_lsb;
    bit    e_vld, e_src;
    item_t e_item;
    bit    saw_alu_block, saw_lsb_block;

    task automatic cycle(input bit rst, input bit clr, input bit rdy);
        bit    ra, rb, acc_a, acc_b, real_a, real_b, has_a, has_b, emp_a, emp_b;
        int    win;
        item_t in_a, in_b, ca, cb;
        rst_in    = rst;
        clear     = clr;
        rdy_in    = rdy;
        alu_valid = (sa.size() > 0);
        lsb_valid = (sb.size() > 0);
        in_a = alu_valid ? sa[0] : item_t'({$urandom, $urandom});
        in_b = lsb_valid ? sb[0] : item_t'({$urandom, $urandom});
        alu_tag = in_a.tag; alu_value = in_a.val;
        lsb_tag = in_b.tag; lsb_value = in_b.val;
        #1;
        ra = (qa.size() < DEP);
        rb = (qb.size() < DEP);
        check("alu_ready", alu_ready, ra);
        check("lsb_ready", lsb_ready, rb);
        if (!ra) saw_alu_block = 1;
        if (!rb) saw_lsb_block = 1;
        acc_a = alu_valid && ra && rdy && !clr && !rst;
        acc_b = lsb_valid && rb && rdy && !clr && !rst;
        if (rst || clr) begin
            qa.delete(); qb.delete();
            last_lsb = 1;
            e_vld = 0; e_item = '0; e_src = 0;
        end else if (rdy) begin
            real_a = acc_a && (in_a.tag != 0);
            real_b = acc_b && (in_b.tag != 0);
            emp_a = (qa.size() == 0);
            emp_b = (qb.size() == 0);
            has_a = !emp_a || real_a;
            has_b = !emp_b || real_b;
            ca = emp_a ? in_a : qa[0];
            cb = emp_b ? in_b : qb[0];
            if (has_a && has_b) win = last_lsb ? 0 : 1;
            else if (has_a)     win = 0;
            else if (has_b)     win = 1;
            else                win = -1;
            if (win == 0) begin e_vld = 1; e_item = ca; e_src = 0; last_lsb = 0; end
            else if (win == 1) begin e_vld = 1; e_item = cb; e_src = 1; last_lsb = 1; end
            else begin e_vld = 0; e_item = '0; e_src = 0; end
            if (win == 0 && !emp_a) void'(qa.pop_front());
            if (win == 1 && !emp_b) void'(qb.pop_front());
            if (real_a && !(win == 0 && emp_a)) qa.push_back(in_a);
            if (real_b && !(win == 1 && emp_b)) qb.push_back(in_b);
        end
        if (acc_a) void'(sa.pop_front());
        if (acc_b) void'(sb.pop_front());
        @(posedge clk_in);
        #1;
        check("cdb_valid", cdb_valid, e_vld);
        check("cdb_tag",   cdb_tag,   e_item.tag);
        check("cdb_value", cdb_value, e_item.val);
        check("cdb_src",   cdb_src,   e_src);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1);
    endtask

    initial begin
        rst_in = 1; rdy_in = 1; clear = 0;
        alu_valid = 0; lsb_valid = 0;
        alu_tag = '0; lsb_tag = '0; alu_value = '0; lsb_value = '0;
        last_lsb = 1; e_vld = 0; e_item = '0; e_src = 0;
        saw_alu_block = 0; saw_lsb_block = 0;
        repeat (2) @(posedge clk_in);
        #1;
        cycle(1, 0, 1);

        // single ALU result
        sa.push_back('{4'd3, 32'h11});
        run(3);

        // simultaneous first results from reset: ALU wins, then LSB
        cycle(1, 0, 1);
        sa.push_back('{4'd2, 32'hA});
        sb.push_back('{4'd5, 32'hB});
        run(3);

        // continuous pushes on both sides until both FIFOs fill and drain
        cycle(1, 0, 1);
        for (int i = 0; i < 12; i++) begin
            sa.push_back('{4'(1 + i % 15), 32'h100 + 32'(i)});
            sb.push_back('{4'(1 + (i + 7) % 15), 32'h200 + 32'(i)});
        end
        run(40);
        check("alu_ready_dropped", saw_alu_block, 1);
        check("lsb_ready_dropped", saw_lsb_block, 1);

        // clear with pending FIFOs and fresh inputs on the bus
        cycle(1, 0, 1);
        for (int i = 0; i < 8; i++) begin
            sa.push_back('{4'(1 + i), 32'hC00 + 32'(i)});
            sb.push_back('{4'(9 + i % 7), 32'hD00 + 32'(i)});
        end
        run(6);
        cycle(0, 1, 1);
        sa.delete(); sb.delete();
        run(4);

        // tag-0 drop followed by a rdy_in freeze with results pending
        cycle(1, 0, 1);
        sa.push_back('{4'd0, 32'h55});
        sa.push_back('{4'd9, 32'h99});
        sa.push_back('{4'd10, 32'hAA});
        sb.push_back('{4'd6, 32'h66});
        sb.push_back('{4'd7, 32'h77});
        run(2);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        run(6);

        // randomised traffic with occasional freeze, clear and reset
        cycle(1, 0, 1);
        for (int i = 0; i < 800; i++) begin
            if (sa.size() == 0 && $urandom_range(0, 99) < 60)
                sa.push_back('{4'($urandom_range(0, 15)), 32'($urandom)});
            if (sb.size() == 0 && $urandom_range(0, 99) < 60)
                sb.push_back('{4'($urandom_range(0, 15)), 32'($urandom)});
            cycle($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 80);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
